fb_write_arbiter: RTL and testbench

//  Shares the single write port of the frame-buffer RAM between N_REQ pixel

---
 rtl/fb_write_arbiter_if.sv | 32 +++
 rtl/fb_write_arbiter.sv | 153 +++++++++++++++
 tb/tb_fb_write_arbiter.sv | 356 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fb_write_arbiter_if.sv
// -----------------------------------------------------------------------------
// fb_write_arbiter_if
// Requester-side bundle of the frame-buffer write arbiter: one valid/ready
// handshake per pixel drawer plus the packed address/data/last of each beat.
//   req_valid [N_REQ]         drawer i has a beat pending
//   req_last  [N_REQ]         that beat is the final one of drawer i's burst
//   req_addr  [N_REQ*ADDR_W]  slice i = [i*ADDR_W +: ADDR_W]
//   req_data  [N_REQ*DATA_W]  slice i = [i*DATA_W +: DATA_W]
//   req_ready [N_REQ]         arbiter accepted drawer i's beat this cycle
// master = drawers side, slave = arbiter side.
// -----------------------------------------------------------------------------
interface fb_write_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int ADDR_W = 19,
    parameter int DATA_W = 12
);
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ-1:0]        req_last;
    logic [N_REQ*ADDR_W-1:0] req_addr;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        req_ready;

    modport master (
        output req_valid, req_last, req_addr, req_data,
        input  req_ready
    );

    modport slave (
        input  req_valid, req_last, req_addr, req_data,
        output req_ready
    );
endinterface

// File: rtl/fb_write_arbiter.sv
// -----------------------------------------------------------------------------
// fb_write_arbiter
// Shares the single write port of the frame-buffer RAM between N_REQ pixel
// drawers with round-robin arbitration and bounded bursts. Beats are only
// accepted while the scan-out reader is blanked, so reads and writes of the
// RAM never collide. Everything runs on the rising edge of pclk.
// Ports:
//   pclk, rst        pixel clock, synchronous active-high reset
//   vblnk, hblnk     blanking flags; either one opens the write window
//   req_if           drawer handshake bundle (slave modport)
//   fb_we/addr/data  registered RAM write port, one cycle after acceptance
//   grant_id         current or most recent granted drawer
//   busy             high while a grant is active
//   err_oob          one-cycle pulse after an accepted beat with addr >= FB_DEPTH
// -----------------------------------------------------------------------------
module fb_write_arbiter #(
    parameter int          N_REQ     = 4,
    parameter int          ADDR_W    = 19,
    parameter int          DATA_W    = 12,
    parameter int unsigned FB_DEPTH  = 480000,
    parameter int          MAX_BURST = 16
) (
    input  logic                     pclk,
    input  logic                     rst,
    input  logic                     vblnk,
    input  logic                     hblnk,
    fb_write_arbiter_if.slave        req_if,
    output logic                     fb_we,
    output logic [ADDR_W-1:0]        fb_addr,
    output logic [DATA_W-1:0]        fb_data,
    output logic [$clog2(N_REQ)-1:0] grant_id,
    output logic                     busy,
    output logic                     err_oob
);
    localparam int GW = $clog2(N_REQ);

    typedef enum logic {S_IDLE, S_GRANT} state_t;

    state_t            state_q, state_d;
    logic [GW-1:0]     grant_q, grant_d;
    logic [GW-1:0]     last_grant_q, last_grant_d;
    logic [7:0]        beat_cnt_q, beat_cnt_d;
    logic              fb_we_q, fb_we_d;
    logic [ADDR_W-1:0] fb_addr_q, fb_addr_d;
    logic [DATA_W-1:0] fb_data_q, fb_data_d;
    logic              err_oob_q, err_oob_d;

    logic              win;
    logic [N_REQ-1:0]  ready;
    logic [GW-1:0]     idx;
    logic [GW-1:0]     pick;
    logic              found;
    logic [ADDR_W-1:0] g_addr;
    logic [DATA_W-1:0] g_data;
    logic              accept;
    logic [7:0]        beat_inc;

    always_comb begin
        win      = vblnk | hblnk;
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        beat_cnt_d   = beat_cnt_q;
        fb_we_d      = 1'b0;
        fb_addr_d    = fb_addr_q;
        fb_data_d    = fb_data_q;
        err_oob_d    = 1'b0;
        ready    = '0;
        idx      = '0;
        pick     = grant_q;
        found    = 1'b0;
        accept   = 1'b0;
        beat_inc = beat_cnt_q + 8'd1;
        g_addr   = req_if.req_addr[int'(grant_q)*ADDR_W +: ADDR_W];
        g_data   = req_if.req_data[int'(grant_q)*DATA_W +: DATA_W];

        case (state_q)
            S_IDLE: begin
                // Search starts just after the last winner so every drawer
                // gets a turn before any drawer is served twice.
                for (int k = 1; k <= N_REQ; k++) begin
                    idx = GW'((int'(last_grant_q) + k) % N_REQ);
                    if (!found && req_if.req_valid[idx]) begin
                        found = 1'b1;
                        pick  = idx;
                    end
                end
                if (found) begin
                    grant_d    = pick;
                    beat_cnt_d = 8'd0;
                    state_d    = S_GRANT;
                end
            end
            S_GRANT: begin
                ready[grant_q] = win & req_if.req_valid[grant_q];
                accept         = ready[grant_q];
                if (accept) begin
                    beat_cnt_d = beat_inc;
                    // Out-of-range beats are swallowed so a buggy drawer
                    // cannot stall the port; only the error pulse remains.
                    if (32'(g_addr) < FB_DEPTH) begin
                        fb_we_d   = 1'b1;
                        fb_addr_d = g_addr;
                        fb_data_d = g_data;
                    end else begin
                        err_oob_d = 1'b1;
                    end
                    if (req_if.req_last[grant_q] || beat_inc == 8'(MAX_BURST)) begin
                        state_d      = S_IDLE;
                        last_grant_d = grant_q;
                    end
                end else if (win && !req_if.req_valid[grant_q]) begin
                    // Abandon only counts while the window is open; a closed
                    // window never takes the grant away.
                    state_d      = S_IDLE;
                    last_grant_d = grant_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            grant_q      <= '0;
            last_grant_q <= GW'(N_REQ - 1);
            beat_cnt_q   <= 8'd0;
            fb_we_q      <= 1'b0;
            fb_addr_q    <= '0;
            fb_data_q    <= '0;
            err_oob_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            beat_cnt_q   <= beat_cnt_d;
            fb_we_q      <= fb_we_d;
            fb_addr_q    <= fb_addr_d;
            fb_data_q    <= fb_data_d;
            err_oob_q    <= err_oob_d;
        end
    end

    assign req_if.req_ready = ready;
    assign fb_we    = fb_we_q;
    assign fb_addr  = fb_addr_q;
    assign fb_data  = fb_data_q;
    assign grant_id = grant_q;
    assign busy     = (state_q == S_GRANT);
    assign err_oob  = err_oob_q;

endmodule

// File: tb/tb_fb_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fb_write_arbiter
// Directed bench for fb_write_arbiter (N_REQ=4, MAX_BURST=16, FB_DEPTH=480000).
// Inputs change 1 ns after the rising edge; outputs are sampled 1 ns later.
// -----------------------------------------------------------------------------
module tb_fb_write_arbiter;
    localparam int N_REQ  = 4;
    localparam int ADDR_W = 19;
    localparam int DATA_W = 12;

    logic              pclk = 1'b0;
    logic              rst;
    logic              vblnk;
    logic              hblnk;
    logic              fb_we;
    logic [ADDR_W-1:0] fb_addr;
    logic [DATA_W-1:0] fb_data;
    logic [1:0]        grant_id;
    logic              busy;
    logic              err_oob;

    int tests = 0;
    int fails = 0;

    always #5 pclk = ~pclk;

    fb_write_arbiter_if #(.N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    fb_write_arbiter #(
        .N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .FB_DEPTH(480000), .MAX_BURST(16)
    ) dut (
        .pclk     (pclk),
        .rst      (rst),
        .vblnk    (vblnk),
        .hblnk    (hblnk),
        .req_if   (bus),
        .fb_we    (fb_we),
        .fb_addr  (fb_addr),
        .fb_data  (fb_data),
        .grant_id (grant_id),
        .busy     (busy),
        .err_oob  (err_oob)
    );

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic l,
                           input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        bus.req_valid[i] = v;
        bus.req_last[i]  = l;
        bus.req_addr[i*ADDR_W +: ADDR_W] = a;
        bus.req_data[i*DATA_W +: DATA_W] = d;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        vblnk = 1'b0;
        hblnk = 1'b0;
        bus.req_valid = '0;
        bus.req_last  = '0;
        bus.req_addr  = '0;
        bus.req_data  = '0;
        repeat (3) tick();
        rst = 1'b0;
    endtask

    // Reset values, then single-beat bursts from all four drawers rotate 0,1,2,3.
    task automatic test_reset();
        logic [3:0] exp_r;
        rst = 1'b1;
        vblnk = 1'b1;
        hblnk = 1'b0;
        bus.req_valid = '0;
        bus.req_last  = '0;
        for (int i = 0; i < N_REQ; i++)
            set_req(i, 1'b1, 1'b1, ADDR_W'(i * 10 + 5), DATA_W'(i + 1));
        for (int c = 0; c < 3; c++) begin
            tick(); #1;
            tests++;
            if (fb_we !== 1'b0 || busy !== 1'b0 || grant_id !== 2'd0 || err_oob !== 1'b0 ||
                bus.req_ready !== 4'b0 || fb_addr !== '0 || fb_data !== '0) begin
                fails++;
                $display("FAIL reset_state cyc%0d: we=%b busy=%b gid=%0d err=%b rdy=%b addr=%0d data=%0h, want all zero",
                         c, fb_we, busy, grant_id, err_oob, bus.req_ready, fb_addr, fb_data);
            end
        end
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            exp_r = 4'b0001 << (k % 4);
            tick(); #1;
            tests++;
            if (busy !== 1'b1 || grant_id !== 2'(k % 4) || bus.req_ready !== exp_r) begin
                fails++;
                $display("FAIL rr_grant%0d: busy=%b gid=%0d rdy=%b, want busy=1 gid=%0d rdy=%b",
                         k, busy, grant_id, bus.req_ready, k % 4, exp_r);
            end
            tick(); #1;
            tests++;
            if (busy !== 1'b0 || fb_we !== 1'b1 || fb_addr !== ADDR_W'((k % 4) * 10 + 5) ||
                fb_data !== DATA_W'((k % 4) + 1)) begin
                fails++;
                $display("FAIL rr_write%0d: busy=%b we=%b addr=%0d data=%0h, want 0 1 %0d %0h",
                         k, busy, fb_we, fb_addr, fb_data, (k % 4) * 10 + 5, (k % 4) + 1);
            end
        end
    endtask

    // Drawer 1: five-beat burst at addresses 100..104.
    task automatic test_burst();
        do_reset();
        hblnk = 1'b1;
        set_req(1, 1'b1, 1'b0, 19'd100, 12'h100);
        tick(); #1;
        tests++;
        if (busy !== 1'b1 || grant_id !== 2'd1) begin
            fails++;
            $display("FAIL burst_grant: busy=%b gid=%0d, want 1 1", busy, grant_id);
        end
        for (int b = 0; b < 5; b++) begin
            set_req(1, 1'b1, (b == 4), ADDR_W'(100 + b), DATA_W'(12'h100 + b));
            #1;
            tests++;
            if (bus.req_ready !== 4'b0010) begin
                fails++;
                $display("FAIL burst_ready%0d: rdy=%b, want 0010", b, bus.req_ready);
            end
            tick();
            if (b == 4) set_req(1, 1'b0, 1'b0, '0, '0);
            #1;
            tests++;
            if (fb_we !== 1'b1 || fb_addr !== ADDR_W'(100 + b) || fb_data !== DATA_W'(12'h100 + b) ||
                busy !== (b != 4)) begin
                fails++;
                $display("FAIL burst_beat%0d: we=%b addr=%0d data=%0h busy=%b, want 1 %0d %0h %b",
                         b, fb_we, fb_addr, fb_data, busy, 100 + b, 12'h100 + b, b != 4);
            end
        end
        tick(); #1;
        tests++;
        if (fb_we !== 1'b0) begin
            fails++;
            $display("FAIL burst_after: we=%b, want 0", fb_we);
        end
    endtask

    // Drawer 0 streams without last; drawer 2 sends single beats. Bursts cap at 16.
    task automatic test_max_burst();
        do_reset();
        vblnk = 1'b1;
        set_req(0, 1'b1, 1'b0, 19'd1000, 12'h000);
        set_req(2, 1'b1, 1'b1, 19'd2000, 12'h2aa);
        tick(); #1;
        tests++;
        if (busy !== 1'b1 || grant_id !== 2'd0) begin
            fails++;
            $display("FAIL mb_first_grant: busy=%b gid=%0d, want 1 0", busy, grant_id);
        end
        for (int rnd = 0; rnd < 2; rnd++) begin
            for (int b = 0; b < 16; b++) begin
                set_req(0, 1'b1, 1'b0, ADDR_W'(1000 + rnd * 16 + b), DATA_W'(rnd * 16 + b));
                #1;
                tests++;
                if (bus.req_ready !== 4'b0001) begin
                    fails++;
                    $display("FAIL mb_ready r%0d b%0d: rdy=%b, want 0001", rnd, b, bus.req_ready);
                end
                tick(); #1;
                tests++;
                if (fb_we !== 1'b1 || fb_addr !== ADDR_W'(1000 + rnd * 16 + b)) begin
                    fails++;
                    $display("FAIL mb_write r%0d b%0d: we=%b addr=%0d, want 1 %0d",
                             rnd, b, fb_we, fb_addr, 1000 + rnd * 16 + b);
                end
            end
            tests++;
            if (busy !== 1'b0) begin
                fails++;
                $display("FAIL mb_idle r%0d: busy=%b, want 0 after 16 beats", rnd, busy);
            end
            tick(); #1;
            tests++;
            if (busy !== 1'b1 || grant_id !== 2'd2 || bus.req_ready !== 4'b0100) begin
                fails++;
                $display("FAIL mb_grant2 r%0d: busy=%b gid=%0d rdy=%b, want 1 2 0100",
                         rnd, busy, grant_id, bus.req_ready);
            end
            tick(); #1;
            tests++;
            if (fb_we !== 1'b1 || fb_addr !== 19'd2000 || fb_data !== 12'h2aa || busy !== 1'b0) begin
                fails++;
                $display("FAIL mb_write2 r%0d: we=%b addr=%0d data=%0h busy=%b, want 1 2000 2aa 0",
                         rnd, fb_we, fb_addr, fb_data, busy);
            end
            tick(); #1;
            tests++;
            if (busy !== 1'b1 || grant_id !== 2'd0) begin
                fails++;
                $display("FAIL mb_regrant0 r%0d: busy=%b gid=%0d, want 1 0", rnd, busy, grant_id);
            end
        end
    endtask

    // Eight-beat burst; blanking closes for 10 cycles after beat 3.
    task automatic test_blanking();
        do_reset();
        hblnk = 1'b1;
        set_req(0, 1'b1, 1'b0, 19'd300, 12'h300);
        tick();
        for (int b = 0; b < 8; b++) begin
            if (b == 3) begin
                hblnk = 1'b0;
                for (int c = 0; c < 10; c++) begin
                    #1;
                    tests++;
                    if (bus.req_ready !== 4'b0 || busy !== 1'b1 || grant_id !== 2'd0) begin
                        fails++;
                        $display("FAIL blank_hold c%0d: rdy=%b busy=%b gid=%0d, want 0000 1 0",
                                 c, bus.req_ready, busy, grant_id);
                    end
                    tick(); #1;
                    tests++;
                    if (fb_we !== 1'b0) begin
                        fails++;
                        $display("FAIL blank_we c%0d: we=%b, want 0", c, fb_we);
                    end
                end
                hblnk = 1'b1;
            end
            set_req(0, 1'b1, (b == 7), ADDR_W'(300 + b), DATA_W'(12'h300 + b));
            #1;
            tests++;
            if (bus.req_ready !== 4'b0001) begin
                fails++;
                $display("FAIL blank_ready b%0d: rdy=%b, want 0001", b, bus.req_ready);
            end
            tick(); #1;
            tests++;
            if (fb_we !== 1'b1 || fb_addr !== ADDR_W'(300 + b)) begin
                fails++;
                $display("FAIL blank_write b%0d: we=%b addr=%0d, want 1 %0d", b, fb_we, fb_addr, 300 + b);
            end
        end
        set_req(0, 1'b0, 1'b0, '0, '0);
        #1;
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL blank_end: busy=%b, want 0", busy);
        end
    endtask

    // Drawer 3: out-of-range beat then the last legal address.
    task automatic test_oob();
        do_reset();
        vblnk = 1'b1;
        set_req(3, 1'b1, 1'b0, 19'd480000, 12'hbad);
        tick(); #1;
        tests++;
        if (busy !== 1'b1 || grant_id !== 2'd3 || bus.req_ready !== 4'b1000) begin
            fails++;
            $display("FAIL oob_grant: busy=%b gid=%0d rdy=%b, want 1 3 1000", busy, grant_id, bus.req_ready);
        end
        tick(); #1;
        tests++;
        if (err_oob !== 1'b1 || fb_we !== 1'b0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL oob_pulse: err=%b we=%b busy=%b, want 1 0 1", err_oob, fb_we, busy);
        end
        set_req(3, 1'b1, 1'b1, 19'd479999, 12'h5a5);
        tick(); #1;
        tests++;
        if (fb_we !== 1'b1 || fb_addr !== 19'd479999 || fb_data !== 12'h5a5 ||
            err_oob !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL oob_edge: we=%b addr=%0d data=%0h err=%b busy=%b, want 1 479999 5a5 0 0",
                     fb_we, fb_addr, fb_data, err_oob, busy);
        end
        set_req(3, 1'b0, 1'b0, '0, '0);
        tick(); #1;
        tests++;
        if (err_oob !== 1'b0 || fb_we !== 1'b0) begin
            fails++;
            $display("FAIL oob_after: err=%b we=%b, want 0 0", err_oob, fb_we);
        end
    endtask

    // Reset in the middle of drawer 2's burst, after drawer 1 already won once.
    task automatic test_reset_mid();
        do_reset();
        vblnk = 1'b1;
        set_req(1, 1'b1, 1'b1, 19'd50, 12'h050);
        tick(); #1;
        tests++;
        if (grant_id !== 2'd1 || busy !== 1'b1) begin
            fails++;
            $display("FAIL rm_grant1: gid=%0d busy=%b, want 1 1", grant_id, busy);
        end
        tick();
        set_req(1, 1'b0, 1'b0, '0, '0);
        set_req(2, 1'b1, 1'b0, 19'd60, 12'h060);
        tick(); #1;
        tests++;
        if (grant_id !== 2'd2 || busy !== 1'b1) begin
            fails++;
            $display("FAIL rm_grant2: gid=%0d busy=%b, want 2 1", grant_id, busy);
        end
        tick();
        set_req(2, 1'b1, 1'b0, 19'd61, 12'h061);
        tick(); #1;
        tests++;
        if (fb_we !== 1'b1 || fb_addr !== 19'd61) begin
            fails++;
            $display("FAIL rm_beat2: we=%b addr=%0d, want 1 61", fb_we, fb_addr);
        end
        rst = 1'b1;
        set_req(2, 1'b1, 1'b0, 19'd62, 12'h062);
        tick(); #1;
        tests++;
        if (fb_we !== 1'b0 || busy !== 1'b0 || grant_id !== 2'd0 || bus.req_ready !== 4'b0) begin
            fails++;
            $display("FAIL rm_reset: we=%b busy=%b gid=%0d rdy=%b, want 0 0 0 0000",
                     fb_we, busy, grant_id, bus.req_ready);
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++)
            set_req(i, 1'b1, 1'b1, ADDR_W'(70 + i), DATA_W'(i));
        tick(); #1;
        tests++;
        if (busy !== 1'b1 || grant_id !== 2'd0) begin
            fails++;
            $display("FAIL rm_first_after: busy=%b gid=%0d, want 1 0", busy, grant_id);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_burst();
        test_max_burst();
        test_blanking();
        test_oob();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
